// File: rtl/seq_chunk_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_chunk_adder_pkg
//  Description : Shared types and helpers for the sequential chunked adder.
//                - state_e   : FSM state encoding (IDLE / RUN / DONE)
//                - cnt_width : chunk-counter width, max(1, clog2(n))
//                - full_add  : single-bit full adder, returns {carry, sum}
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A counter for a single chunk still needs one bit to exist.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage : seq_chunk_adder_pkg
`default_nettype wire

// File: rtl/seq_chunk_adder_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_adder
//  Description : Combinational CHUNK-bit ripple-carry adder built from the
//                shared full-adder cell.
//  Ports       : a_i, b_i   - CHUNK-bit addends
//                c_i        - carry in
//                sum_o      - CHUNK-bit sum
//                c_o        - carry out of the chunk MSB
//                c_msb_o    - carry into the chunk MSB (for signed overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign {carry[i+1], sum_o[i]} = full_add(a_i[i], b_i[i], carry[i]);
  end

  assign c_o     = carry[CHUNK];
  assign c_msb_o = carry[CHUNK-1];

endmodule : chunk_adder
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : seq_chunk_adder
//  Description : Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits
//                per clock, carrying between chunks in a register.
//  Ports       : clk, rst_n           - clock, synchronous active-low reset
//                in_valid / in_ready  - operand handshake (ready only in IDLE)
//                in1, in2, cin, sub   - operands, carry-in, subtract select
//                out_valid / out_ready- result handshake (valid only in DONE)
//                out, cout, ovf       - result, carry out, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int            NC   = WIDTH / CHUNK;
  localparam int            CW   = cnt_width(NC);
  localparam logic [CW-1:0] LAST = CW'(NC - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              carry_q, cout_q, ovf_q;
  logic [CW-1:0]     cnt_q;

  logic [CHUNK-1:0]  a_chunk, b_chunk, sum_chunk;
  logic              chunk_co, chunk_cmsb;
  logic              last_chunk;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_chunk = (cnt_q == LAST);

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded purely from the registered state
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_comb begin
    a_chunk = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    b_chunk = b_q[int'(cnt_q)*CHUNK +: CHUNK];
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_i     (a_chunk),
    .b_i     (b_chunk),
    .c_i     (carry_q),
    .sum_o   (sum_chunk),
    .c_o     (chunk_co),
    .c_msb_o (chunk_cmsb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && in_valid) begin
        // Subtraction is A + ~B + 1: invert B once here and seed the carry.
        a_q     <= in1;
        b_q     <= sub ? ~in2 : in2;
        carry_q <= sub ? 1'b1 : cin;
        cnt_q   <= '0;
      end
      if (state_q == ST_RUN) begin
        res_q[int'(cnt_q)*CHUNK +: CHUNK] <= sum_chunk;
        carry_q <= chunk_co;
        cnt_q   <= cnt_q + CW'(1);
        if (last_chunk) begin
          // Carry into the last chunk's MSB is the carry into bit WIDTH-1.
          cout_q <= chunk_co;
          ovf_q  <= chunk_co ^ chunk_cmsb;
        end
      end
    end
  end

  assign out  = res_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : seq_chunk_adder
`default_nettype wire
